// File: rtl/pmp_csr_writer_pkg.sv
// Shared constants and types for the PMP configuration/address write path.
package pmp_csr_writer_pkg;

   localparam logic [1:0] PMP_A_OFF   = 2'b00;
   localparam logic [1:0] PMP_A_TOR   = 2'b01;
   localparam logic [1:0] PMP_A_NA4   = 2'b10;
   localparam logic [1:0] PMP_A_NAPOT = 2'b11;

   localparam logic [11:0] PMPCFG0  = 12'h3A0;
   localparam logic [11:0] PMPADDR0 = 12'h3B0;

   typedef enum logic [1:0] {IDLE, APPLY, FLUSH} pmp_state_t;

endpackage

// File: rtl/pmp_cfg_legalize.sv
// WARL legalization of one pmpcfg byte {L,00,A[1:0],X,W,R} against its current value.
module pmp_cfg_legalize
   import pmp_csr_writer_pkg::*;
#(
   parameter int G = 0
) (
   input  logic [7:0] oldCfg,
   input  logic [7:0] newCfg,
   output logic [7:0] legalCfg
);

   always_comb begin
      legalCfg = {newCfg[7], 2'b00, newCfg[4:0]};
      // NA4 cannot describe a region once the granule exceeds 4 bytes
      if (G >= 1 && newCfg[4:3] == PMP_A_NA4) legalCfg[4:3] = oldCfg[4:3];
      if (oldCfg[7] || (newCfg[1] && !newCfg[0])) legalCfg = oldCfg;
   end

endmodule

// File: rtl/pmp_csr_writer.sv
// Owns the PMP cfg/addr arrays; applies legalized CSR writes and requests a flush after any change.
module pmp_csr_writer
   import pmp_csr_writer_pkg::*;
#(
   parameter int XLEN        = 64,
   parameter int PA_BITS     = 56,
   parameter int PMP_ENTRIES = 16,
   parameter int PMP_G       = 0
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               CSRWriteValid,
   output logic               CSRWriteReady,
   input  logic [11:0]        CSRAdr,
   input  logic [XLEN-1:0]    CSRWriteData,
   input  logic [11:0]        CSRReadAdr,
   output logic [XLEN-1:0]    CSRReadData,
   output logic [7:0]         PMPCFG_ARRAY_REGW  [(PMP_ENTRIES > 0 ? PMP_ENTRIES : 1)-1:0],
   output logic [PA_BITS-3:0] PMPADDR_ARRAY_REGW [(PMP_ENTRIES > 0 ? PMP_ENTRIES : 1)-1:0],
   output logic               PMPFlushReq,
   input  logic               PMPFlushAck
);

   localparam int NE        = (PMP_ENTRIES > 0) ? PMP_ENTRIES : 1;
   localparam int AW        = PA_BITS - 2;
   localparam int CFG_BYTES = XLEN / 8;
   localparam int CFG_STEP  = CFG_BYTES / 4;

   pmp_state_t      state;
   logic [11:0]     adrLatched;
   logic [XLEN-1:0] dataLatched;
   logic            changed;

   function automatic logic [AW-1:0] readAddr(input logic [AW-1:0] stored, input logic [1:0] mode);
      logic [AW-1:0] r;
      r = stored;
      for (int b = 0; b < AW; b++) begin
         if ((mode == PMP_A_OFF || mode == PMP_A_TOR) && b < PMP_G) r[b] = 1'b0;
         if (mode == PMP_A_NAPOT && b < PMP_G - 1) r[b] = 1'b1;
      end
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= IDLE;
         CSRWriteReady <= 1'b1;
         PMPFlushReq   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (CSRWriteValid && CSRWriteReady) begin
               adrLatched    <= CSRAdr;
               dataLatched   <= CSRWriteData;
               state         <= APPLY;
               CSRWriteReady <= 1'b0;
            end
            APPLY: if (changed) begin
               state       <= FLUSH;
               PMPFlushReq <= 1'b1;
            end else begin
               state         <= IDLE;
               CSRWriteReady <= 1'b1;
            end
            FLUSH: if (PMPFlushAck) begin
               state         <= IDLE;
               PMPFlushReq   <= 1'b0;
               CSRWriteReady <= 1'b1;
            end
            default: begin
               state         <= IDLE;
               CSRWriteReady <= 1'b1;
               PMPFlushReq   <= 1'b0;
            end
         endcase
      end
   end

   if (PMP_ENTRIES > 0) begin : gPmp
      logic [7:0]    legalByte [NE];
      logic [7:0]    cfgNext   [NE];
      logic [AW-1:0] addrNext  [NE];
      logic [NE-1:0] entryChanged;
      logic [NE-1:0] lockedByNext;
      logic [AW-1:0] addrData;

      assign addrData = AW'(dataLatched);

      for (genvar i = 0; i < NE; i++) begin : gEntry
         pmp_cfg_legalize #(.G(PMP_G)) uLegal (
            .oldCfg   (PMPCFG_ARRAY_REGW[i]),
            .newCfg   (dataLatched[8*(i%CFG_BYTES) +: 8]),
            .legalCfg (legalByte[i])
         );
         // a locked TOR entry also freezes the base address held in the entry below it
         if (i + 1 < NE) begin : gTor
            assign lockedByNext[i] = PMPCFG_ARRAY_REGW[i+1][7] &&
                                     (PMPCFG_ARRAY_REGW[i+1][4:3] == PMP_A_TOR);
         end else begin : gLast
            assign lockedByNext[i] = 1'b0;
         end
      end

      always_comb begin
         for (int i = 0; i < NE; i++) begin
            cfgNext[i]  = PMPCFG_ARRAY_REGW[i];
            addrNext[i] = PMPADDR_ARRAY_REGW[i];
            if (adrLatched == 12'(PMPCFG0 + (i / CFG_BYTES) * CFG_STEP))
               cfgNext[i] = legalByte[i];
            if (adrLatched == 12'(PMPADDR0 + i) && !PMPCFG_ARRAY_REGW[i][7] && !lockedByNext[i])
               addrNext[i] = addrData;
            entryChanged[i] = (cfgNext[i] != PMPCFG_ARRAY_REGW[i]) ||
                              (addrNext[i] != PMPADDR_ARRAY_REGW[i]);
         end
      end

      assign changed = |entryChanged;

      always_ff @(posedge clk) begin
         for (int i = 0; i < NE; i++) begin
            if (!reset_n) begin
               PMPCFG_ARRAY_REGW[i]  <= '0;
               PMPADDR_ARRAY_REGW[i] <= '0;
            end else if (state == APPLY) begin
               PMPCFG_ARRAY_REGW[i]  <= cfgNext[i];
               PMPADDR_ARRAY_REGW[i] <= addrNext[i];
            end
         end
      end

      always_comb begin
         CSRReadData = '0;
         for (int i = 0; i < NE; i++) begin
            if (CSRReadAdr == 12'(PMPCFG0 + (i / CFG_BYTES) * CFG_STEP))
               CSRReadData[8*(i%CFG_BYTES) +: 8] = PMPCFG_ARRAY_REGW[i];
            if (CSRReadAdr == 12'(PMPADDR0 + i))
               CSRReadData = XLEN'(readAddr(PMPADDR_ARRAY_REGW[i], PMPCFG_ARRAY_REGW[i][4:3]));
         end
      end
   end else begin : gNoPmp
      assign changed               = 1'b0;
      assign CSRReadData           = '0;
      assign PMPCFG_ARRAY_REGW[0]  = '0;
      assign PMPADDR_ARRAY_REGW[0] = '0;
   end

endmodule
